// File: rtl/mux_scan_pkg.sv
// Shared definitions for the 4:1 mux scan sequencer: channel geometry and FSM state encoding.
package mux_scan_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2
   } state_t;

endpackage

// File: rtl/mux_settle_cnt.sv
// Loadable down-counter with a zero flag; times the settle window after each select change.
module mux_settle_cnt #(
   parameter int CNT_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_dec,
   output logic             o_zero
);

   logic [CNT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/mux_scan_seq.sv
// Scan sequencer: steps the mux select over all channels, samples after a settle window,
// and hands the assembled word downstream over a valid/ready register with overrun flag.
module mux_scan_seq
   import mux_scan_pkg::*;
#(
   parameter int SETTLE_CYC = 1,
   parameter int CNT_W      = 4
) (
   input  logic              clk_in,
   input  logic              rst_n_in,
   input  logic              start_in,
   input  logic              mode_in,
   input  logic              stop_in,
   input  logic              mux_y_in,
   output logic [SEL_W-1:0]  sel_out,
   output logic [NUM_CH-1:0] word_out,
   output logic              valid_out,
   input  logic              ready_in,
   output logic              busy_out,
   output logic              overrun_out
);

   localparam bit               HAS_SETTLE = (SETTLE_CYC != 0);
   localparam logic [CNT_W-1:0] LOAD_VAL   = HAS_SETTLE ? CNT_W'(SETTLE_CYC - 1) : '0;
   localparam logic [SEL_W-1:0] LAST_SEL   = SEL_W'(NUM_CH - 1);
   // With no settle time every channel is sampled on consecutive cycles.
   localparam state_t           CH_STATE   = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;

   state_t              r_state;
   logic [SEL_W-1:0]    r_sel;
   logic [NUM_CH-1:0]   r_part;
   logic [NUM_CH-1:0]   r_word;
   logic                r_valid;
   logic                r_busy;
   logic                r_overrun;
   logic                r_mode;

   logic                w_start_ok;
   logic                w_sample;
   logic                w_last;
   logic                w_more;
   logic                w_load;
   logic                w_dec;
   logic                w_cnt_zero;
   logic [NUM_CH-1:0]   w_new_word;

   always_comb begin
      w_start_ok = (r_state == ST_IDLE) && start_in && !stop_in;
      w_sample   = (r_state == ST_SAMPLE) && !stop_in;
      w_last     = (r_sel == LAST_SEL);
      w_more     = w_sample && (!w_last || r_mode);
      w_load     = HAS_SETTLE && (w_start_ok || w_more);
      w_dec      = (r_state == ST_SETTLE) && !stop_in && !w_cnt_zero;
      w_new_word = r_part;
      w_new_word[r_sel] = mux_y_in;
   end

   mux_settle_cnt #(
      .CNT_W(CNT_W)
   ) u_settle_cnt (
      .i_clk      (clk_in),
      .i_rst_n    (rst_n_in),
      .i_load     (w_load),
      .i_load_val (LOAD_VAL),
      .i_dec      (w_dec),
      .o_zero     (w_cnt_zero)
   );

   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         r_state   <= ST_IDLE;
         r_sel     <= '0;
         r_part    <= '0;
         r_word    <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
         r_mode    <= 1'b0;
      end else begin
         if (r_valid && ready_in) begin
            r_valid <= 1'b0;
         end

         case (r_state)
            ST_IDLE: begin
               if (w_start_ok) begin
                  r_mode    <= mode_in;
                  r_sel     <= '0;
                  r_part    <= '0;
                  r_overrun <= 1'b0;
                  r_busy    <= 1'b1;
                  r_state   <= CH_STATE;
               end
            end

            ST_SETTLE: begin
               if (stop_in) begin
                  r_state <= ST_IDLE;
                  r_sel   <= '0;
                  r_part  <= '0;
                  r_busy  <= 1'b0;
               end else if (w_cnt_zero) begin
                  r_state <= ST_SAMPLE;
               end
            end

            ST_SAMPLE: begin
               if (stop_in) begin
                  r_state <= ST_IDLE;
                  r_sel   <= '0;
                  r_part  <= '0;
                  r_busy  <= 1'b0;
               end else if (!w_last) begin
                  r_part  <= w_new_word;
                  r_sel   <= r_sel + 1'b1;
                  r_state <= CH_STATE;
               end else begin
                  r_part <= '0;
                  r_sel  <= '0;
                  // A word still held un-accepted wins; the fresh one is dropped.
                  if (!r_valid || ready_in) begin
                     r_word  <= w_new_word;
                     r_valid <= 1'b1;
                  end else begin
                     r_overrun <= 1'b1;
                  end
                  if (r_mode) begin
                     r_state <= CH_STATE;
                  end else begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
            end

            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign sel_out     = r_sel;
   assign word_out    = r_word;
   assign valid_out   = r_valid;
   assign busy_out    = r_busy;
   assign overrun_out = r_overrun;

endmodule

// File: tb/tb_mux_scan_seq.sv
// Directed bench for mux_scan_seq: one instance with a one-cycle settle, one with none,
// each fed by a behavioural 4:1 mux built from the shared data nibble.
module tb_mux_scan_seq;

   logic       clk;
   logic       rst_n;
   logic       start1;
   logic       start0;
   logic       mode;
   logic       stop;
   logic       ready;
   logic [3:0] d;

   logic [1:0] sel1, sel0;
   logic [3:0] word1, word0;
   logic       valid1, valid0, busy1, busy0, ovr1, ovr0;
   logic       y1, y0;

   int n_cmp = 0;
   int n_err = 0;

   assign y1 = d[sel1];
   assign y0 = d[sel0];

   mux_scan_seq #(.SETTLE_CYC(1), .CNT_W(4)) dut1 (
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start1), .mode_in(mode),
      .stop_in(stop), .mux_y_in(y1), .sel_out(sel1), .word_out(word1),
      .valid_out(valid1), .ready_in(ready), .busy_out(busy1), .overrun_out(ovr1)
   );

   mux_scan_seq #(.SETTLE_CYC(0), .CNT_W(4)) dut0 (
      .clk_in(clk), .rst_n_in(rst_n), .start_in(start0), .mode_in(mode),
      .stop_in(stop), .mux_y_in(y0), .sel_out(sel0), .word_out(word0),
      .valid_out(valid0), .ready_in(ready), .busy_out(busy0), .overrun_out(ovr0)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", tag, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic tickn(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic go1();
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
   endtask

   logic [1:0] sel_exp [0:8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
   logic [1:0] sel0_exp [0:4] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

   initial begin
      rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0; mode = 1'b0;
      stop = 1'b0; ready = 1'b1; d = 4'b0000;
      tickn(2);
      check_val("rst_sel1",   8'(sel1),   8'h0);
      check_val("rst_word1",  8'(word1),  8'h0);
      check_val("rst_valid1", 8'(valid1), 8'h0);
      check_val("rst_busy1",  8'(busy1),  8'h0);
      check_val("rst_ovr1",   8'(ovr1),   8'h0);
      check_val("rst_valid0", 8'(valid0), 8'h0);
      rst_n = 1'b1;
      tick();

      // Single-shot, one settle cycle per channel.
      d = 4'b1010; mode = 1'b0; ready = 1'b1;
      go1();
      for (int k = 0; k <= 9; k++) begin
         if (k <= 8) check_val($sformatf("ss_sel_e%0d", k), 8'(sel1), 8'(sel_exp[k]));
         check_val($sformatf("ss_valid_e%0d", k), 8'(valid1), (k == 8) ? 8'h1 : 8'h0);
         if (k == 7) check_val("ss_busy_e7", 8'(busy1), 8'h1);
         if (k == 8) begin
            check_val("ss_word", 8'(word1), 8'h0A);
            check_val("ss_busy_e8", 8'(busy1), 8'h0);
         end
         if (k < 9) tick();
      end

      // No settle: select advances every cycle.
      d = 4'b0110;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      for (int k = 0; k <= 4; k++) begin
         check_val($sformatf("z_sel_e%0d", k), 8'(sel0), 8'(sel0_exp[k]));
         check_val($sformatf("z_valid_e%0d", k), 8'(valid0), (k == 4) ? 8'h1 : 8'h0);
         if (k < 4) tick();
      end
      check_val("z_word", 8'(word0), 8'h06);
      tick();

      // Continuous with back-pressure and overrun.
      d = 4'b1100; mode = 1'b1; ready = 1'b0;
      go1();
      tickn(8);
      check_val("bp_valid_e8", 8'(valid1), 8'h1);
      check_val("bp_word_e8",  8'(word1),  8'h0C);
      check_val("bp_ovr_e8",   8'(ovr1),   8'h0);
      tickn(8);
      check_val("bp_ovr_e16",   8'(ovr1),   8'h1);
      check_val("bp_word_e16",  8'(word1),  8'h0C);
      check_val("bp_valid_e16", 8'(valid1), 8'h1);
      ready = 1'b1; d = 4'b0011;
      tick();
      check_val("bp_valid_e17", 8'(valid1), 8'h0);
      tickn(7);
      check_val("bp_valid_e24", 8'(valid1), 8'h1);
      check_val("bp_word_e24",  8'(word1),  8'h03);
      check_val("bp_ovr_e24",   8'(ovr1),   8'h1);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_val("bp_stop_busy", 8'(busy1), 8'h0);
      check_val("bp_stop_sel",  8'(sel1),  8'h0);

      // Accept and completion in the same cycle.
      d = 4'b0101; mode = 1'b1; ready = 1'b0;
      go1();
      check_val("sim_ovr_cleared", 8'(ovr1), 8'h0);
      tickn(8);
      check_val("sim_word1", 8'(word1), 8'h05);
      d = 4'b1001;
      tickn(7);
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check_val("sim_valid_e16", 8'(valid1), 8'h1);
      check_val("sim_word_e16",  8'(word1),  8'h09);
      check_val("sim_ovr_e16",   8'(ovr1),   8'h0);
      stop = 1'b1;
      tick();
      stop = 1'b0;

      // Abort mid-scan, then reset mid-scan.
      ready = 1'b1; mode = 1'b0; d = 4'b1010;
      tick();
      go1();
      tickn(2);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_val("ab_busy", 8'(busy1), 8'h0);
      check_val("ab_sel",  8'(sel1),  8'h0);
      check_val("ab_valid", 8'(valid1), 8'h0);
      tickn(8);
      check_val("ab_no_word", 8'(valid1), 8'h0);
      go1();
      tickn(4);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_val("mr_sel",   8'(sel1),   8'h0);
      check_val("mr_busy",  8'(busy1),  8'h0);
      check_val("mr_valid", 8'(valid1), 8'h0);
      check_val("mr_word",  8'(word1),  8'h0);
      d = 4'b0111;
      go1();
      tickn(8);
      check_val("mr_new_valid", 8'(valid1), 8'h1);
      check_val("mr_new_word",  8'(word1),  8'h07);
      tick();

      // Stop beats start in IDLE.
      start1 = 1'b1; stop = 1'b1;
      tick();
      start1 = 1'b0; stop = 1'b0;
      check_val("pri_busy", 8'(busy1), 8'h0);
      tickn(3);
      check_val("pri_busy_later", 8'(busy1), 8'h0);
      check_val("pri_valid", 8'(valid1), 8'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
